// File: rtl/audio_clip_scheduler_if.sv
// Request, sample-ROM and status signals shared between the clip scheduler
// (slave side) and the game logic / ROM / speaker driver (master side).
interface audio_clip_scheduler_if #(
  parameter int NUM_CLIPS = 4,
  parameter int ADDR_W    = 16,
  parameter int ID_W      = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
);
  logic [NUM_CLIPS-1:0] Req_In;
  logic                 Stop_In;
  logic                 Rom_Data_In;
  logic [ADDR_W-1:0]    Rom_Addr_Out;
  logic                 Rom_Rd_Out;
  logic                 Audio_Out;
  logic                 Busy_Out;
  logic [ID_W-1:0]      Active_Id_Out;
  logic                 Grant_Out;
  logic                 Done_Out;
  logic [NUM_CLIPS-1:0] Pending_Out;

  modport slave (
    input  Req_In, Stop_In, Rom_Data_In,
    output Rom_Addr_Out, Rom_Rd_Out, Audio_Out, Busy_Out,
           Active_Id_Out, Grant_Out, Done_Out, Pending_Out
  );

  modport master (
    output Req_In, Stop_In, Rom_Data_In,
    input  Rom_Addr_Out, Rom_Rd_Out, Audio_Out, Busy_Out,
           Active_Id_Out, Grant_Out, Done_Out, Pending_Out
  );
endinterface

// File: rtl/audio_clip_scheduler.sv
// Shares one 1-bit sample ROM between prioritised sound-effect clips:
// latches requests, grants with preemption and streams one sample per tick.
module audio_clip_scheduler #(
  parameter int                          NUM_CLIPS = 4,
  parameter int                          TICK_DIV  = 4535,
  parameter int                          ADDR_W    = 16,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_BASE = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
  parameter logic [NUM_CLIPS*16-1:0]     CLIP_LEN  = {4{16'd22050}}
) (
  input  logic                  Master_Clock_In,
  input  logic                  Master_Reset_N_In,
  audio_clip_scheduler_if.slave sched_if
);

  localparam int ID_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;
  localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [NUM_CLIPS-1:0] pending_q, pending_d;
  logic [15:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ID_W-1:0]      active_q, active_d;
  logic                 rd_q, rd_d;
  logic                 audio_q, audio_d;
  logic                 grant_q, grant_d;
  logic                 done_q, done_d;

  logic [ADDR_W-1:0]    base_arr [NUM_CLIPS];
  logic [15:0]          len_arr  [NUM_CLIPS];
  logic [NUM_CLIPS-1:0] req_ok;
  logic [NUM_CLIPS-1:0] grant_mask;
  logic [ID_W-1:0]      winner;
  logic                 pend_any;
  logic                 tick_edge;
  logic                 start_play;

  // Zero-length clips are filtered here so they can never become pending.
  generate
    for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_clip
      assign base_arr[gi] = CLIP_BASE[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]  = CLIP_LEN[gi*16 +: 16];
      assign req_ok[gi]   = sched_if.Req_In[gi] && (len_arr[gi] != 16'd0);
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (pending_q[i]) winner = ID_W'(i);
    end
  end

  assign pend_any   = |pending_q;
  assign tick_edge  = (tick_cnt_q == TCW'(TICK_DIV - 1));
  assign tick_cnt_d = tick_edge ? '0 : tick_cnt_q + TCW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    active_d   = active_q;
    rd_d       = 1'b0;
    grant_d    = 1'b0;
    done_d     = 1'b0;
    audio_d    = rd_q ? sched_if.Rom_Data_In : audio_q;
    grant_mask = '0;
    start_play = 1'b0;

    if (tick_edge) begin
      case (state_q)
        ST_IDLE: start_play = pend_any;
        ST_PLAY: begin
          if (pend_any && (winner < active_q)) begin
            start_play = 1'b1;
          end else if (idx_q == len_arr[active_q]) begin
            done_d = 1'b1;
            if (pend_any) begin
              start_play = 1'b1;
            end else begin
              state_d = ST_IDLE;
              audio_d = 1'b0;
            end
          end else begin
            addr_d = base_arr[active_q] + ADDR_W'(idx_q);
            rd_d   = 1'b1;
            idx_d  = idx_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (start_play) begin
      state_d            = ST_PLAY;
      active_d           = winner;
      grant_d            = 1'b1;
      addr_d             = base_arr[winner];
      rd_d               = 1'b1;
      idx_d              = 16'd1;
      grant_mask[winner] = 1'b1;
    end

    // A request arriving on the granting edge re-arms the bit (set wins).
    pending_d = (pending_q & ~grant_mask) | req_ok;

    if (sched_if.Stop_In) begin
      state_d   = ST_IDLE;
      pending_d = '0;
      audio_d   = 1'b0;
      rd_d      = 1'b0;
      grant_d   = 1'b0;
      done_d    = 1'b0;
      addr_d    = addr_q;
      idx_d     = idx_q;
      active_d  = active_q;
    end
  end

  always_ff @(posedge Master_Clock_In or negedge Master_Reset_N_In) begin
    if (!Master_Reset_N_In) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      pending_q  <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      active_q   <= '0;
      rd_q       <= 1'b0;
      audio_q    <= 1'b0;
      grant_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      active_q   <= active_d;
      rd_q       <= rd_d;
      audio_q    <= audio_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign sched_if.Rom_Addr_Out  = addr_q;
  assign sched_if.Rom_Rd_Out    = rd_q;
  assign sched_if.Audio_Out     = audio_q;
  assign sched_if.Busy_Out      = (state_q == ST_PLAY);
  assign sched_if.Active_Id_Out = active_q;
  assign sched_if.Grant_Out     = grant_q;
  assign sched_if.Done_Out      = done_q;
  assign sched_if.Pending_Out   = pending_q;

endmodule

// File: tb/tb_audio_clip_scheduler.sv
// Scoreboard bench for audio_clip_scheduler: expected grant/read/done events
// are queued with each stimulus and popped as the DUT emits them.
module tb_audio_clip_scheduler;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam logic [1:0] K_GRANT = 2'd1;
  localparam logic [1:0] K_RD    = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_clip_scheduler_if #(.NUM_CLIPS(NC), .ADDR_W(AW)) bus ();

  audio_clip_scheduler #(
    .NUM_CLIPS(NC),
    .TICK_DIV (4),
    .ADDR_W   (AW),
    .CLIP_BASE({16'h0300, 16'h0200, 16'h0100, 16'hFFFE}),
    .CLIP_LEN ({16'd2, 16'd3, 16'd0, 16'd4})
  ) dut (
    .Master_Clock_In  (clk),
    .Master_Reset_N_In(rst_n),
    .sched_if         (bus)
  );

  function automatic logic rom_bit(input logic [15:0] a);
    return a[0] ^ a[8] ^ a[15];
  endfunction

  assign bus.Rom_Data_In = rom_bit(bus.Rom_Addr_Out);

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  dg_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, 32'({k, v}), 32'({e.kind, e.val}));
  endtask

  // Monitor: Stop_In is captured at the edge so the audio check knows
  // whether the capture on that edge was suppressed.
  logic        rd_seen   = 1'b0;
  logic        stop_seen = 1'b0;
  logic [15:0] addr_seen = '0;

  always @(posedge clk) stop_seen <= bus.Stop_In;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_seen <= 1'b0;
    end else begin
      if (rd_seen)
        chk("audio_capture", 32'(bus.Audio_Out),
            32'(stop_seen ? 1'b0 : rom_bit(addr_seen)));
      if (bus.Done_Out) pop_cmp("done_event", K_DONE, 16'h0);
      if (bus.Grant_Out) begin
        pop_cmp("grant_event", K_GRANT, 16'(bus.Active_Id_Out));
        chk("busy_at_grant", 32'(bus.Busy_Out), 32'd1);
      end
      if (bus.Done_Out && bus.Grant_Out) dg_count <= dg_count + 1;
      if (bus.Rom_Rd_Out) pop_cmp("read_event", K_RD, bus.Rom_Addr_Out);
      rd_seen   <= bus.Rom_Rd_Out;
      addr_seen <= bus.Rom_Addr_Out;
    end
  end

  task automatic pulse_req(input logic [NC-1:0] m);
    bus.Req_In = m;
    @(posedge clk);
    #1 bus.Req_In = '0;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.Busy_Out),      32'd0);
    chk({tag, "_audio"},   32'(bus.Audio_Out),     32'd0);
    chk({tag, "_grant"},   32'(bus.Grant_Out),     32'd0);
    chk({tag, "_done"},    32'(bus.Done_Out),      32'd0);
    chk({tag, "_rd"},      32'(bus.Rom_Rd_Out),    32'd0);
    chk({tag, "_addr"},    32'(bus.Rom_Addr_Out),  32'd0);
    chk({tag, "_id"},      32'(bus.Active_Id_Out), 32'd0);
    chk({tag, "_pending"}, 32'(bus.Pending_Out),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    int c;
    int dg0;
    bus.Req_In  = '0;
    bus.Stop_In = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single clip 0 with address wrap
    push(K_GRANT, 16'h0);
    push(K_RD, 16'hFFFE);
    push(K_RD, 16'hFFFF);
    push(K_RD, 16'h0000);
    push(K_RD, 16'h0001);
    push(K_DONE, 16'h0);
    pulse_req(4'b0001);
    wait_sb("t1_drain", 60);
    chk("t1_busy_after", 32'(bus.Busy_Out), 32'd0);
    chk("t1_audio_after", 32'(bus.Audio_Out), 32'd0);

    // Preemption of clip 3 by clip 0
    push(K_GRANT, 16'h3);
    push(K_RD, 16'h0300);
    pulse_req(4'b1000);
    wait_sb("t2_first_read", 40);
    push(K_GRANT, 16'h0);
    push(K_RD, 16'hFFFE);
    push(K_RD, 16'hFFFF);
    push(K_RD, 16'h0000);
    push(K_RD, 16'h0001);
    push(K_DONE, 16'h0);
    pulse_req(4'b0001);
    wait_sb("t2_drain", 60);
    chk("t2_busy_after", 32'(bus.Busy_Out), 32'd0);

    // Chaining clip 2 into clip 3 on the same edge
    dg0 = dg_count;
    push(K_GRANT, 16'h2);
    push(K_RD, 16'h0200);
    push(K_RD, 16'h0201);
    push(K_RD, 16'h0202);
    push(K_DONE, 16'h0);
    push(K_GRANT, 16'h3);
    push(K_RD, 16'h0300);
    push(K_RD, 16'h0301);
    push(K_DONE, 16'h0);
    pulse_req(4'b1100);
    chk("t3_pending", 32'(bus.Pending_Out), 32'h0000_000C);
    wait_sb("t3_drain", 80);
    chk("t3_done_grant_same_edge", 32'(dg_count - dg0), 32'd1);
    chk("t3_busy_after", 32'(bus.Busy_Out), 32'd0);

    // Zero-length clip never becomes pending
    pulse_req(4'b0010);
    chk("t4_pending_now", 32'(bus.Pending_Out), 32'd0);
    idle_cycles(10);
    chk("t4_pending_later", 32'(bus.Pending_Out), 32'd0);
    chk("t4_busy", 32'(bus.Busy_Out), 32'd0);

    // Stop mid-clip between reads, with a simultaneous request
    push(K_GRANT, 16'h0);
    push(K_RD, 16'hFFFE);
    push(K_RD, 16'hFFFF);
    pulse_req(4'b0001);
    wait_sb("t5a_two_reads", 60);
    chk("t5a_audio_before", 32'(bus.Audio_Out), 32'd1);
    bus.Stop_In = 1'b1;
    bus.Req_In  = 4'b0100;
    @(posedge clk);
    #1;
    bus.Stop_In = 1'b0;
    bus.Req_In  = '0;
    chk("t5a_busy", 32'(bus.Busy_Out), 32'd0);
    chk("t5a_audio", 32'(bus.Audio_Out), 32'd0);
    chk("t5a_pending", 32'(bus.Pending_Out), 32'd0);
    idle_cycles(12);
    chk("t5a_quiet", 32'(exp_q.size()), 32'd0);

    // Stop during a read cycle suppresses that capture
    push(K_GRANT, 16'h2);
    push(K_RD, 16'h0200);
    push(K_RD, 16'h0201);
    pulse_req(4'b0100);
    c = 0;
    while (!(bus.Rom_Rd_Out && bus.Rom_Addr_Out == 16'h0201) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("t5b_read_seen", 32'(c < 60), 32'd1);
    bus.Stop_In = 1'b1;
    @(posedge clk);
    #1;
    bus.Stop_In = 1'b0;
    chk("t5b_audio", 32'(bus.Audio_Out), 32'd0);
    chk("t5b_busy", 32'(bus.Busy_Out), 32'd0);
    idle_cycles(12);
    chk("t5b_quiet", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-clip
    push(K_GRANT, 16'h3);
    push(K_RD, 16'h0300);
    pulse_req(4'b1000);
    wait_sb("t5c_first_read", 40);
    chk("t5c_audio_before", 32'(bus.Audio_Out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t5c_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // Replay of the clip already playing
    push(K_GRANT, 16'h3);
    push(K_RD, 16'h0300);
    pulse_req(4'b1000);
    wait_sb("t6_first_read", 40);
    dg0 = dg_count;
    push(K_RD, 16'h0301);
    push(K_DONE, 16'h0);
    push(K_GRANT, 16'h3);
    push(K_RD, 16'h0300);
    push(K_RD, 16'h0301);
    push(K_DONE, 16'h0);
    pulse_req(4'b1000);
    chk("t6_pending", 32'(bus.Pending_Out), 32'h0000_0008);
    wait_sb("t6_drain", 60);
    chk("t6_regrant_same_edge", 32'(dg_count - dg0), 32'd1);
    chk("t6_busy_after", 32'(bus.Busy_Out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
